// File: rtl/main_memory_pkg.sv
// Shared types and default geometry for the main_memory block.
// Default widths here match the main_memory parameter defaults.
package main_memory_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int BLOCK_SIZE_DEF     = 16;
  localparam int MEM_DEPTH_DEF      = 1024;
  localparam int LATENCY_DEF        = 10;
  localparam int HIT_LATENCY_DEF    = 3;
  localparam int BLOCKS_PER_ROW_DEF = 8;

  localparam int OFFSET_W = $clog2(BLOCK_SIZE_DEF);
  localparam int INDEX_W  = $clog2(MEM_DEPTH_DEF);
  localparam int ROW_W    = INDEX_W - $clog2(BLOCKS_PER_ROW_DEF);

  typedef logic [BLOCK_SIZE_DEF*DATA_WIDTH_DEF-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_row_tracker.sv
// Open-row tracker: remembers the last accessed row and picks the access latency.
// Only instantiated by main_memory when ROW_BUFFER_EN is defined.
module mem_row_tracker #(
  parameter int ROW_W       = 7,
  parameter int LAT_W       = 4,
  parameter int LATENCY     = 10,
  parameter int HIT_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             hit_o,
  output logic [LAT_W-1:0] lat_o
);

  logic [ROW_W-1:0] open_row_q;
  logic             row_valid_q;

  // Every accepted access, read or write, opens its row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_row_q  <= '0;
      row_valid_q <= 1'b0;
    end else if (acc_i) begin
      open_row_q  <= row_i;
      row_valid_q <= 1'b1;
    end
  end

  assign hit_o = row_valid_q && (open_row_q == row_i);
  assign lat_o = hit_o ? LAT_W'(HIT_LATENCY) : LAT_W'(LATENCY);

endmodule

// File: rtl/main_memory.sv
// Block-granular main memory behind the L2: capture, wait latency, one-cycle mem_ready.
// Build option ROW_BUFFER_EN adds an open-row buffer with shorter row-hit latency (mem_hit).
module main_memory
  import main_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int BLOCK_SIZE     = BLOCK_SIZE_DEF,
  parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
  parameter int LATENCY        = LATENCY_DEF,
  parameter int HIT_LATENCY    = HIT_LATENCY_DEF,
  parameter int BLOCKS_PER_ROW = BLOCKS_PER_ROW_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
  input  logic                             mem_read,
  input  logic                             mem_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
  output logic                             mem_ready,
  output logic                             mem_hit
);

  localparam int BLK_W    = BLOCK_SIZE * DATA_WIDTH;
  localparam int OFF_BITS = $clog2(BLOCK_SIZE);
  localparam int IDX_BITS = $clog2(MEM_DEPTH);
  localparam int LAT_W    = $clog2(LATENCY + 1);

  function automatic logic [BLK_W-1:0] init_block(input int b);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int w = 0; w < BLOCK_SIZE; w++) begin
      v[w*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(b * BLOCK_SIZE + w);
    end
    return v;
  endfunction

  state_e               state_q;
  logic [LAT_W-1:0]     cnt_q;
  logic                 ready_q;
  logic                 hit_q;
  logic [BLK_W-1:0]     rdata_q;
  logic [BLK_W-1:0]     rdata_d;

  logic [IDX_BITS-1:0]  idx_q;
  logic                 we_q;
  logic [BLK_W-1:0]     wdata_q;
  logic                 acc_hit_q;

  logic [IDX_BITS-1:0]  req_idx;
  logic                 req;
  logic                 accept;
  logic                 acc_hit;
  logic [LAT_W-1:0]     acc_lat;

  logic                 commit_en;
  logic                 commit_we;
  logic [IDX_BITS-1:0]  commit_idx;
  logic [BLK_W-1:0]     commit_wdata;
  logic [BLK_W-1:0]     store_rd [MEM_DEPTH];

  logic                 unused_addr;

  // Offset bits and address bits above the index wrap silently.
  assign req_idx     = mem_addr[OFF_BITS +: IDX_BITS];
  assign unused_addr = ^{mem_addr[OFF_BITS-1:0], mem_addr[ADDR_WIDTH-1:OFF_BITS+IDX_BITS]};
  assign req         = mem_read || mem_write;
  assign accept      = (state_q == IDLE) && req;

`ifdef ROW_BUFFER_EN
  localparam int ROW_BITS = IDX_BITS - $clog2(BLOCKS_PER_ROW);

  mem_row_tracker #(
    .ROW_W      (ROW_BITS),
    .LAT_W      (LAT_W),
    .LATENCY    (LATENCY),
    .HIT_LATENCY(HIT_LATENCY)
  ) u_row_tracker (
    .clk  (clk),
    .rst_n(rst_n),
    .acc_i(accept),
    .row_i(req_idx[IDX_BITS-1 -: ROW_BITS]),
    .hit_o(acc_hit),
    .lat_o(acc_lat)
  );
`else
  localparam int unused_row_cfg = HIT_LATENCY + BLOCKS_PER_ROW;

  assign acc_hit = 1'b0;
  assign acc_lat = LAT_W'(LATENCY);
`endif

  // Commit edge: end of BUSY, or the accepting edge itself for a one-cycle
  // latency, in which case the live request fields are used.
  always_comb begin
    commit_en    = 1'b0;
    commit_we    = we_q;
    commit_idx   = idx_q;
    commit_wdata = wdata_q;
    if (accept && (acc_lat == LAT_W'(1))) begin
      commit_en    = rst_n;
      commit_we    = mem_write;
      commit_idx   = req_idx;
      commit_wdata = mem_wdata;
    end else if ((state_q == BUSY) && (cnt_q == '0)) begin
      commit_en = rst_n;
    end
  end

  assign rdata_d = commit_we ? commit_wdata : store_rd[commit_idx];

  // Storage holds its contents across reset.
  for (genvar b = 0; b < MEM_DEPTH; b++) begin : g_store
    logic [BLK_W-1:0] blk_q = init_block(b);

    always_ff @(posedge clk) begin
      if (commit_en && commit_we && (commit_idx == IDX_BITS'(b))) begin
        blk_q <= commit_wdata;
      end
    end

    assign store_rd[b] = blk_q;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q     <= req_idx;
      we_q      <= mem_write;
      wdata_q   <= mem_wdata;
      acc_hit_q <= acc_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      if (commit_en) begin
        rdata_q <= rdata_d;
      end
      unique case (state_q)
        IDLE: begin
          if (req) begin
            cnt_q <= acc_lat - LAT_W'(1);
            if (acc_lat == LAT_W'(1)) begin
              state_q <= RESPOND;
              ready_q <= 1'b1;
              hit_q   <= acc_hit;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= RESPOND;
            ready_q <= 1'b1;
            hit_q   <= acc_hit_q;
          end else begin
            cnt_q <= cnt_q - LAT_W'(1);
          end
        end
        RESPOND: state_q <= RELEASE;
        // A request still held from the last access must drop before re-arming.
        RELEASE: begin
          if (!mem_read && !mem_write) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_hit   = hit_q;

endmodule

// File: tb/tb_main_memory.sv
// Table-driven bench for main_memory with a response scoreboard queue.
// Row-buffer sequences run only when ROW_BUFFER_EN is defined.
module tb_main_memory;
  import main_memory_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wbase;
    logic [31:0] ebase;
  } vec_t;

  typedef struct {
    logic [31:0] ebase;
    int          lat;
    bit          hit;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  block_t      mem_wdata;
  logic        mem_read;
  logic        mem_write;
  block_t      mem_rdata;
  logic        mem_ready;
  logic        mem_hit;

  int total;
  int bad;
  exp_t exp_q[$];
  vec_t tbl[7];

  bit              m_row_valid;
  logic [ROW_W-1:0] m_open_row;

  main_memory dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_hit  (mem_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic block_t mk_block(input logic [31:0] base);
    block_t v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = base + 32'(w);
    return v;
  endfunction

  task automatic chk_i(input string nm, input longint act, input longint req_v);
    total++;
    if (act != req_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req_v);
    end
  endtask

  task automatic chk_b(input string nm, input block_t act, input block_t req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req_v);
    end
  endtask

  // Reference latency/hit for an access, from the tb's own row model.
  task automatic predict(input logic [31:0] addr, output int lat, output bit hit);
    logic [INDEX_W-1:0] idx;
    logic [ROW_W-1:0]   row;
    idx = INDEX_W'(addr >> OFFSET_W);
    row = idx[INDEX_W-1 -: ROW_W];
`ifdef ROW_BUFFER_EN
    hit = m_row_valid && (row == m_open_row);
    lat = hit ? 3 : 10;
`else
    hit = 1'b0;
    lat = 10;
`endif
    m_open_row  = row;
    m_row_valid = 1'b1;
  endtask

  task automatic wait_resp(input string nm);
    exp_t e;
    int   n;
    bit   got;
    if (exp_q.size() == 0) begin
      chk_i({nm, "_sb_empty"}, 0, 1);
      return;
    end
    e   = exp_q.pop_front();
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (mem_ready) got = 1'b1;
    end
    chk_i({nm, "_latency"}, n, e.lat);
    if (got) begin
      chk_b({nm, "_rdata"}, mem_rdata, mk_block(e.ebase));
      chk_i({nm, "_hit"}, mem_hit, e.hit);
      @(posedge clk); #1;
      chk_i({nm, "_pulse_end"}, mem_ready, 0);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v, input bit rel);
    exp_t e;
    @(negedge clk);
    mem_addr  = v.addr;
    mem_read  = v.rd;
    mem_write = v.wr;
    mem_wdata = mk_block(v.wbase);
    e.ebase   = v.ebase;
    predict(v.addr, e.lat, e.hit);
    exp_q.push_back(e);
    @(posedge clk);
    wait_resp(nm);
    if (rel) begin
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    m_row_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_i("rst_ready", mem_ready, 0);
    chk_i("rst_hit", mem_hit, 0);
    chk_b("rst_rdata", mem_rdata, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit   seen;
    vec_t v;
    total = 0;
    bad   = 0;
    m_row_valid = 1'b0;
    m_open_row  = '0;
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    tbl[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h40,   wbase: 32'h0,        ebase: 32'd64};
    tbl[1] = '{rd: 1'b1, wr: 1'b1, addr: 32'h80,   wbase: 32'hA5A50000, ebase: 32'hA5A50000};
    tbl[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'h8C,   wbase: 32'h0,        ebase: 32'hA5A50000};
    tbl[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'h4030, wbase: 32'h0,        ebase: 32'd48};
    tbl[4] = '{rd: 1'b0, wr: 1'b1, addr: 32'h200,  wbase: 32'h12340000, ebase: 32'h12340000};
    tbl[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'h20F,  wbase: 32'h0,        ebase: 32'h12340000};
    tbl[6] = '{rd: 1'b1, wr: 1'b0, addr: 32'h3FF0, wbase: 32'h0,        ebase: 32'd16368};

    repeat (3) @(negedge clk);
    chk_i("rst_ready", mem_ready, 0);
    chk_i("rst_hit", mem_hit, 0);
    chk_b("rst_rdata", mem_rdata, '0);
    rst_n = 1'b1;

    // Write to block 8 aborted by reset five cycles into BUSY.
    @(negedge clk);
    mem_addr  = 32'h80;
    mem_write = 1'b1;
    mem_wdata = '1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    @(negedge clk);
    rst_n     = 1'b1;
    mem_write = 1'b0;
    m_row_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    chk_i("abort_no_ready", seen, 0);
    chk_b("abort_rdata_reset", mem_rdata, '0);
    v = '{rd: 1'b1, wr: 1'b0, addr: 32'h80, wbase: 32'h0, ebase: 32'd128};
    run_vec("abort_readback", v, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i], 1'b1);
    end

    // Held read: no second pulse, then a fresh request after one idle cycle.
    v = '{rd: 1'b1, wr: 1'b0, addr: 32'h10, wbase: 32'h0, ebase: 32'd16};
    run_vec("hold", v, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    chk_i("hold_no_repeat", seen, 0);
    @(negedge clk);
    mem_read = 1'b0;
    v = '{rd: 1'b1, wr: 1'b0, addr: 32'h00, wbase: 32'h0, ebase: 32'd0};
    run_vec("rearm", v, 1'b1);

`ifdef ROW_BUFFER_EN
    do_reset();
    v = '{rd: 1'b1, wr: 1'b0, addr: 32'h40, wbase: 32'h0, ebase: 32'd64};
    run_vec("row_b4", v, 1'b1);
    v = '{rd: 1'b1, wr: 1'b0, addr: 32'h50, wbase: 32'h0, ebase: 32'd80};
    run_vec("row_b5", v, 1'b1);
    v = '{rd: 1'b1, wr: 1'b0, addr: 32'hC0, wbase: 32'h0, ebase: 32'd192};
    run_vec("row_b12", v, 1'b1);
`else
    do_reset();
`endif

    chk_i("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
